// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-programmer parameter readback frame:
// frame length, sync byte, field byte offsets and the frame FSM states.
package pulse_pkg;

    localparam int unsigned FRAME_LEN      = 20;
    localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;

    // Byte offsets within the frame; multi-byte fields are big-endian from here
    localparam logic [4:0] OFF_HEADER          = 5'd0;
    localparam logic [4:0] OFF_PERIOD          = 5'd1;
    localparam logic [4:0] OFF_P1WIDTH         = 5'd5;
    localparam logic [4:0] OFF_DELAY           = 5'd7;
    localparam logic [4:0] OFF_P2WIDTH         = 5'd9;
    localparam logic [4:0] OFF_PULSE_BLOCK     = 5'd11;
    localparam logic [4:0] OFF_PULSE_BLOCK_OFF = 5'd12;
    localparam logic [4:0] OFF_CPMG            = 5'd14;
    localparam logic [4:0] OFF_NUT_DEL         = 5'd15;
    localparam logic [4:0] OFF_NUT_WID         = 5'd17;
    localparam logic [4:0] OFF_FLAGS           = 5'd18;
    localparam logic [4:0] OFF_CHECKSUM        = 5'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, idle high. byte_done fires one cycle before
// the stop bit ends so a reload in that last cycle gives a gapless next start bit.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data,
    input  logic       load,
    output logic       tx,
    output logic       byte_done
);

    localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_EARLY = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]    STOP_BIT  = 4'd9;

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          active;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx      <= 1'b1;
            active  <= 1'b0;
            bit_idx <= '0;
            cnt     <= '0;
            shreg   <= '0;
        end else if (load) begin
            tx      <= 1'b0;
            active  <= 1'b1;
            bit_idx <= '0;
            cnt     <= '0;
            shreg   <= data;
        end else if (active) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (bit_idx == STOP_BIT) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    // ones shift in behind the data, so the ninth shift yields the stop bit
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[7:1]};
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign byte_done = active && (bit_idx == STOP_BIT) && (cnt == CNT_EARLY);

endmodule

// File: rtl/param_readback_tx.sv
// Snapshots the live pulse-timing parameters on start and sends them as one
// 20-byte UART frame: header, big-endian fields, flags, XOR checksum.
module param_readback_tx
    import pulse_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] period,
    input  logic [15:0] p1width,
    input  logic [15:0] delay,
    input  logic [15:0] p2width,
    input  logic [7:0]  pulse_block,
    input  logic [15:0] pulse_block_off,
    input  logic [7:0]  cpmg,
    input  logic [15:0] nut_del,
    input  logic [7:0]  nut_wid,
    input  logic        block,
    output logic        RS232_Tx,
    output logic        busy,
    output logic        done
);

    state_t state, state_next;
    logic [4:0] idx;
    logic [OFF_FLAGS:OFF_PERIOD][7:0] shadow;
    logic [7:0] csum;
    logic [7:0] cur_byte;
    logic       last_done;
    logic       load;
    logic       byte_done;

    always_comb begin
        if (idx == OFF_HEADER)
            cur_byte = HEADER;
        else if (idx == OFF_CHECKSUM)
            cur_byte = csum;
        else
            cur_byte = shadow[idx];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            idx       <= '0;
            shadow    <= '0;
            csum      <= '0;
            last_done <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_SNAP: begin
                    shadow[OFF_PERIOD]              <= period[31:24];
                    shadow[OFF_PERIOD + 5'd1]       <= period[23:16];
                    shadow[OFF_PERIOD + 5'd2]       <= period[15:8];
                    shadow[OFF_PERIOD + 5'd3]       <= period[7:0];
                    shadow[OFF_P1WIDTH]             <= p1width[15:8];
                    shadow[OFF_P1WIDTH + 5'd1]      <= p1width[7:0];
                    shadow[OFF_DELAY]               <= delay[15:8];
                    shadow[OFF_DELAY + 5'd1]        <= delay[7:0];
                    shadow[OFF_P2WIDTH]             <= p2width[15:8];
                    shadow[OFF_P2WIDTH + 5'd1]      <= p2width[7:0];
                    shadow[OFF_PULSE_BLOCK]         <= pulse_block;
                    shadow[OFF_PULSE_BLOCK_OFF]     <= pulse_block_off[15:8];
                    shadow[OFF_PULSE_BLOCK_OFF+5'd1]<= pulse_block_off[7:0];
                    shadow[OFF_CPMG]                <= cpmg;
                    shadow[OFF_NUT_DEL]             <= nut_del[15:8];
                    shadow[OFF_NUT_DEL + 5'd1]      <= nut_del[7:0];
                    shadow[OFF_NUT_WID]             <= nut_wid;
                    shadow[OFF_FLAGS]               <= {7'b0, block};
                    idx       <= '0;
                    csum      <= '0;
                    last_done <= 1'b0;
                end
                S_LOAD: begin
                    if (idx != OFF_HEADER && idx != OFF_CHECKSUM)
                        csum <= csum ^ cur_byte;
                end
                S_SEND: begin
                    if (byte_done) begin
                        if (idx != OFF_CHECKSUM)
                            idx <= idx + 5'd1;
                        else
                            last_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Inter-byte reloads land in the last stop-bit cycle; the final byte waits
    // one extra cycle (last_done) so done follows the full stop bit.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_SNAP;
            S_SNAP: begin
                busy       = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                load       = 1'b1;
                state_next = S_SEND;
            end
            S_SEND: begin
                busy = 1'b1;
                if (byte_done && idx != OFF_CHECKSUM)
                    state_next = S_LOAD;
                else if (last_done)
                    state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .resetn   (resetn),
        .data     (cur_byte),
        .load     (load),
        .tx       (RS232_Tx),
        .byte_done(byte_done)
    );

endmodule
